riscv_multicycle_core: RTL and testbench

RISCV_MULTICYCLE_CORE -- requirements
Module: riscv_multicycle_core

---
 rtl/riscv_multicycle_core.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_riscv_multicycle_core.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_core.sv
// Multicycle RV32I subset core: fetch, decode, exec, mem, writeback.
// Illegal or misaligned work parks the core in a sticky trap state.
module riscv_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        retire,
  output logic        trap
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam int          AW   = $clog2(NUM_REGS);
  localparam logic [5:0]  NREG = 6'(NUM_REGS);

  state_t      state, state_nx;
  logic        run;
  logic [31:0] pc, ir;
  logic [31:0] rs1_q, rs2_q, imm_q;
  logic [31:0] res_q, npc_q;
  logic [31:0] rf [NUM_REGS];

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;

  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  logic is_op, is_opi, is_lui, is_aui;
  logic is_jal, is_jalr, is_br, is_ld, is_st;

  assign is_op   = opc == 7'h33;
  assign is_opi  = opc == 7'h13;
  assign is_lui  = opc == 7'h37;
  assign is_aui  = opc == 7'h17;
  assign is_jal  = opc == 7'h6f;
  assign is_jalr = opc == 7'h67;
  assign is_br   = opc == 7'h63;
  assign is_ld   = opc == 7'h03;
  assign is_st   = opc == 7'h23;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};

  logic [31:0] imm;
  logic        legal, use_rd, use_rs1, use_rs2;

  always_comb begin
    imm     = '0;
    legal   = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    unique case (1'b1)
      is_op: begin
        legal   = (f7 == 7'h00) ||
                  (f7 == 7'h20 &&
                   (f3 == 3'b000 || f3 == 3'b101));
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      is_opi: begin
        imm     = imm_i;
        if (f3 == 3'b001)
          legal = f7 == 7'h00;
        else if (f3 == 3'b101)
          legal = f7 == 7'h00 || f7 == 7'h20;
        else
          legal = 1'b1;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      is_lui, is_aui: begin
        imm    = imm_u;
        legal  = 1'b1;
        use_rd = 1'b1;
      end
      is_jal: begin
        imm    = imm_j;
        legal  = 1'b1;
        use_rd = 1'b1;
      end
      is_jalr: begin
        imm     = imm_i;
        legal   = f3 == 3'b000;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      is_br: begin
        imm     = imm_b;
        legal   = !f3[1];
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      is_ld: begin
        imm     = imm_i;
        legal   = f3 == 3'b010;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      is_st: begin
        imm     = imm_s;
        legal   = f3 == 3'b010;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  logic bad_reg, illegal, wr_en;

  assign bad_reg = (use_rd  && {1'b0, rd}  >= NREG) ||
                   (use_rs1 && {1'b0, rs1} >= NREG) ||
                   (use_rs2 && {1'b0, rs2} >= NREG);
  assign illegal = !legal || bad_reg;
  assign wr_en   = use_rd && rd != 5'd0;

  logic [31:0] opb, alu, sum_ai, pc4, pc_imm;
  logic [31:0] res, npc;
  logic        alt, lt, take, misalign;

  assign opb    = (is_op || is_br) ? rs2_q : imm_q;
  assign alt    = f7[5] &&
                  (is_op || (is_opi && f3 == 3'b101));
  assign sum_ai = rs1_q + imm_q;
  assign pc4    = pc + 32'd4;
  assign pc_imm = pc + imm_q;
  assign lt     = $signed(rs1_q) < $signed(rs2_q);

  always_comb begin
    case (f3)
      3'b000: alu = alt ? rs1_q - opb : rs1_q + opb;
      3'b001: alu = rs1_q << opb[4:0];
      3'b010: alu = {31'b0, $signed(rs1_q) < $signed(opb)};
      3'b011: alu = {31'b0, rs1_q < opb};
      3'b100: alu = rs1_q ^ opb;
      3'b101: alu = alt ? 32'($signed(rs1_q) >>> opb[4:0])
                        : rs1_q >> opb[4:0];
      3'b110: alu = rs1_q | opb;
      default: alu = rs1_q & opb;
    endcase
  end

  always_comb begin
    if (f3[2])
      take = f3[0] ? !lt : lt;
    else
      take = f3[0] ? (rs1_q != rs2_q) : (rs1_q == rs2_q);
  end

  always_comb begin
    res = alu;
    npc = pc4;
    unique case (1'b1)
      is_lui:       res = imm_q;
      is_aui:       res = pc_imm;
      is_jal: begin
        res = pc4;
        npc = pc_imm;
      end
      is_jalr: begin
        res = pc4;
        npc = {sum_ai[31:1], 1'b0};
      end
      is_br:        npc = take ? pc_imm : pc4;
      is_ld, is_st: res = sum_ai;
      default: ;
    endcase
  end

  assign misalign = (npc[1:0] != 2'b00) ||
                    ((is_ld || is_st) && sum_ai[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_FETCH;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (run && imem_ready) state_nx = S_DECODE;
      S_DECODE: state_nx = illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (misalign)
          state_nx = S_TRAP;
        else if (is_ld || is_st)
          state_nx = S_MEM;
        else
          state_nx = S_WB;
      end
      S_MEM:    if (dmem_ready) state_nx = S_WB;
      S_WB:     state_nx = S_FETCH;
      default:  state_nx = S_TRAP;
    endcase
  end

  always_comb begin
    imem_req = run && state == S_FETCH;
    dmem_req = state == S_MEM;
    dmem_we  = state == S_MEM && is_st;
    retire   = state == S_WB;
    trap     = state == S_TRAP;
  end

  // run holds the first fetch off until one edge after reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run   <= 1'b0;
      pc    <= RESET_PC;
      ir    <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      res_q <= '0;
      npc_q <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        S_FETCH:  if (run && imem_ready) ir <= imem_rdata;
        S_DECODE: begin
          rs1_q <= rf[rs1[AW-1:0]];
          rs2_q <= rf[rs2[AW-1:0]];
          imm_q <= imm;
        end
        S_EXEC: begin
          res_q <= res;
          npc_q <= npc;
        end
        S_MEM:    if (dmem_ready && !is_st) res_q <= dmem_rdata;
        S_WB:     pc <= npc_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] <= '0;
    end else if (state == S_WB && wr_en) begin
      rf[rd[AW-1:0]] <= res_q;
    end
  end

  assign imem_addr       = pc;
  assign dmem_addr       = res_q;
  assign dmem_wdata      = rs2_q;
  assign pc_out          = pc;
  assign instruction_out = ir;

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core with simple memory models.
// Register results are observed through stores to data memory.
module tb_riscv_multicycle_core;

  localparam int OPI = 7'h13;
  localparam int LD  = 7'h03;
  localparam int JR  = 7'h67;
  localparam logic [31:0] ILL = 32'h0000_007f;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc_out, instruction_out;
  logic        retire, trap;

  riscv_multicycle_core #(
    .RESET_PC(32'h0000_0000),
    .NUM_REGS(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata),
    .pc_out(pc_out),
    .instruction_out(instruction_out),
    .retire(retire),
    .trap(trap)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int dly = 0;
  int dcnt = 0;

  assign imem_rdata = imem[imem_addr[7:2]];
  assign dmem_rdata = dmem[dmem_addr[7:2]];
  assign dmem_ready = dmem_req && (dcnt >= dly);

  always @(posedge clk)
    if (dmem_req && !dmem_ready) dcnt <= dcnt + 1;
    else dcnt <= 0;

  int cyc = 0, both = 0, trap_act = 0, unstable = 0;
  int req_len = 0, dreq_cyc = 0;
  logic        prev_req = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = '0, p_wd = '0;
  int          ret_cyc[$];
  int          acc_len[$];
  logic [31:0] fetch_q[$], st_addr[$], st_data[$];

  always @(negedge clk) begin
    cyc++;
    if (imem_req && dmem_req) both++;
    if (trap && (imem_req || dmem_req || retire)) trap_act++;
    if (retire) ret_cyc.push_back(cyc);
    if (imem_req && imem_ready) fetch_q.push_back(imem_addr);
    if (dmem_req) begin
      dreq_cyc++;
      if (prev_req && (dmem_addr != p_addr ||
          dmem_we != p_we || dmem_wdata != p_wd))
        unstable++;
      req_len++;
      if (dmem_ready) begin
        acc_len.push_back(req_len);
        req_len = 0;
        if (dmem_we) begin
          st_addr.push_back(dmem_addr);
          st_data.push_back(dmem_wdata);
          dmem[dmem_addr[7:2]] = dmem_wdata;
        end
      end
    end else begin
      req_len = 0;
    end
    prev_req = dmem_req && !dmem_ready;
    p_addr = dmem_addr;
    p_we = dmem_we;
    p_wd = dmem_wdata;
  end

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm,
    input int rs1, input int f3, input int rd, input int op);
    logic [11:0] v;
    v = 12'(imm);
    return {v, 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] enc_r(input int f7,
    input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input int imm,
    input int rs2, input int rs1);
    logic [11:0] v;
    v = 12'(imm);
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm,
    input int rs2, input int rs1, input int f3);
    logic [12:0] v;
    v = 13'(imm);
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3),
            v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] v;
    v = 21'(imm);
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20,
    input int rd, input int op);
    return {20'(imm20), 5'(rd), 7'(op)};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_imem();
    foreach (imem[i]) imem[i] = ILL;
  endtask

  task automatic do_reset(input bit chk);
    reset = 1'b1;
    #1;
    if (chk) begin
      check("rst_imem_req", 32'(imem_req), 0);
      check("rst_dmem_req", 32'(dmem_req), 0);
      check("rst_dmem_we", 32'(dmem_we), 0);
      check("rst_retire", 32'(retire), 0);
      check("rst_trap", 32'(trap), 0);
      check("rst_pc", pc_out, 32'h0);
      check("rst_ir", instruction_out, 32'h0);
    end
    step();
    step();
    ret_cyc.delete();
    acc_len.delete();
    fetch_q.delete();
    st_addr.delete();
    st_data.delete();
    unstable = 0;
    trap_act = 0;
    dreq_cyc = 0;
    foreach (dmem[i]) dmem[i] = '0;
    reset = 1'b0;
    #1;
    if (chk) check("rel_imem_req", 32'(imem_req), 0);
  endtask

  task automatic wait_ret(input int n, input int budget,
                          input string tag);
    int k = 0;
    while (ret_cyc.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(ret_cyc.size() >= n), 1);
  endtask

  task automatic wait_trap(input int budget, input string tag);
    int k = 0;
    while (!trap && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(trap), 1);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] exp_a [9];
  int          reg_a [9];
  logic [31:0] exp_f [10];
  logic [31:0] tw0 [5], tw1 [5], tir [5];
  logic [31:0] tpc [5];
  int          tret [5];
  int          k;

  initial begin
    imem_ready = 1'b0;
    clear_imem();
    #2;

    // ALU, x0 handling and 4-cycle cadence
    imem[0]  = enc_i(5, 0, 0, 1, OPI);
    imem[1]  = enc_i(-3, 0, 0, 2, OPI);
    imem[2]  = enc_r(0, 2, 1, 0, 3);
    imem[3]  = enc_i(7, 0, 0, 0, OPI);
    imem[4]  = enc_r(0, 0, 0, 0, 5);
    imem[5]  = enc_r(7'h20, 2, 1, 0, 6);
    imem[6]  = enc_r(7'h20, 1, 2, 5, 7);
    imem[7]  = enc_i(28, 2, 5, 8, OPI);
    imem[8]  = enc_r(0, 2, 1, 3, 9);
    imem[9]  = enc_i(0, 2, 2, 10, OPI);
    imem[10] = enc_u(20'h12345, 11, 7'h37);
    imem[11] = enc_u(1, 12, 7'h17);
    reg_a = '{3, 5, 6, 7, 8, 9, 10, 11, 12};
    exp_a = '{32'h2, 32'h0, 32'h8, 32'hffff_ffff, 32'hf,
              32'h1, 32'h1, 32'h1234_5000, 32'h0000_102c};
    for (int i = 0; i < 9; i++)
      imem[12 + i] = enc_s(i * 4, reg_a[i], 0);
    dly = 0;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_req", 32'(imem_req), 1);
      check("hold_addr", imem_addr, 32'h0);
      check("hold_ir", instruction_out, 32'h0);
    end
    imem_ready = 1'b1;
    wait_ret(3, 60, "a_ret3_to");
    step();
    check("a_pc_after3", pc_out, 32'h0000_000c);
    check("a_gap1", 32'(ret_cyc[1] - ret_cyc[0]), 4);
    check("a_gap2", 32'(ret_cyc[2] - ret_cyc[1]), 4);
    wait_trap(300, "a_trap_to");
    check("a_nst", 32'(st_data.size()), 9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("a_st%0d_addr", i), st_addr[i], 32'(i * 4));
      check($sformatf("a_st%0d_data", i), st_data[i], exp_a[i]);
    end
    check("a_sw_cycles", 32'(ret_cyc[12] - ret_cyc[11]), 5);
    check("a_trap_pc", pc_out, 32'h0000_0054);

    // store/load with a 3-cycle data memory stall
    clear_imem();
    imem[0] = enc_i(5, 0, 0, 1, OPI);
    imem[1] = enc_s(8, 1, 0);
    imem[2] = enc_i(8, 0, 2, 4, LD);
    imem[3] = enc_s(12, 4, 0);
    dly = 3;
    do_reset(1'b0);
    wait_trap(200, "b_trap_to");
    check("b_nst", 32'(st_data.size()), 2);
    check("b_st0_addr", st_addr[0], 32'h8);
    check("b_st0_data", st_data[0], 32'h5);
    check("b_st1_addr", st_addr[1], 32'hc);
    check("b_lw_data", st_data[1], 32'h5);
    check("b_sw_req_len", 32'(acc_len[0]), 4);
    check("b_lw_req_len", 32'(acc_len[1]), 4);
    check("b_unstable", 32'(unstable), 0);
    check("b_sw_cycles", 32'(ret_cyc[1] - ret_cyc[0]), 8);
    check("b_lw_cycles", 32'(ret_cyc[2] - ret_cyc[1]), 8);

    // control transfers
    clear_imem();
    imem[0]  = enc_i(32, 0, 0, 2, OPI);
    imem[1]  = enc_b(8, 0, 0, 3'b001);
    imem[2]  = enc_j(8, 3);
    imem[4]  = enc_b(8, 0, 0, 3'b000);
    imem[6]  = enc_i(1, 2, 0, 1, JR);
    imem[8]  = enc_s(0, 1, 0);
    imem[9]  = enc_s(4, 3, 0);
    imem[10] = enc_b(8, 2, 0, 3'b101);
    imem[11] = enc_b(8, 2, 0, 3'b100);
    exp_f = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h18,
              32'h20, 32'h24, 32'h28, 32'h2c, 32'h34};
    dly = 0;
    do_reset(1'b0);
    wait_trap(300, "c_trap_to");
    check("c_nfetch", 32'(fetch_q.size()), 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("c_fetch%0d", i), fetch_q[i], exp_f[i]);
    check("c_jalr_link", st_data[0], 32'h0000_001c);
    check("c_jal_link", st_data[1], 32'h0000_000c);

    // traps: illegal opcode, bad register, bad funct, misalignment
    tw0[0] = enc_i(1, 0, 0, 1, OPI);  tw1[0] = ILL;
    tw0[1] = enc_i(1, 0, 0, 20, OPI); tw1[1] = ILL;
    tw0[2] = enc_i(2, 0, 0, 5, OPI);  tw1[2] = enc_s(2, 5, 0);
    tw0[3] = enc_i(2, 0, 0, 5, OPI);  tw1[3] = enc_i(0, 5, 0, 6, JR);
    tw0[4] = enc_i(1, 0, 0, 1, OPI);  tw1[4] = enc_r(1, 2, 1, 0, 3);
    for (int t = 0; t < 5; t++) begin
      tret[t] = (t == 1) ? 0 : 1;
      tpc[t]  = (t == 1) ? 32'h0 : 32'h4;
      tir[t]  = (t == 1) ? tw0[t] : tw1[t];
    end
    for (int t = 0; t < 5; t++) begin
      clear_imem();
      imem[0] = tw0[t];
      imem[1] = tw1[t];
      do_reset(1'b0);
      wait_trap(60, $sformatf("t%0d_trap_to", t));
      repeat (20) step();
      check($sformatf("t%0d_trap", t), 32'(trap), 1);
      check($sformatf("t%0d_nret", t), 32'(ret_cyc.size()), 32'(tret[t]));
      check($sformatf("t%0d_pc", t), pc_out, tpc[t]);
      check($sformatf("t%0d_ir", t), instruction_out, tir[t]);
      check($sformatf("t%0d_trap_act", t), 32'(trap_act), 0);
      check($sformatf("t%0d_dreq", t), 32'(dreq_cyc), 0);
    end

    // reset in the middle of a stalled store
    clear_imem();
    imem[0] = enc_i(9, 0, 0, 1, OPI);
    imem[1] = enc_s(8, 1, 0);
    dly = 5;
    do_reset(1'b0);
    k = 0;
    while (!dmem_req && k < 40) begin
      step();
      k++;
    end
    check("e_in_mem", 32'(dmem_req), 1);
    step();
    reset = 1'b1;
    #1;
    check("e_dmem_req", 32'(dmem_req), 0);
    check("e_pc", pc_out, 32'h0);
    check("e_trap", 32'(trap), 0);
    check("e_imem_req", 32'(imem_req), 0);
    step();
    reset = 1'b0;
    #1;
    check("e_rel_req", 32'(imem_req), 0);
    step();
    check("e_first_req", 32'(imem_req), 1);
    check("e_first_addr", imem_addr, 32'h0);
    check("e_no_store", 32'(st_data.size()), 0);

    check("both_req", 32'(both), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
